// File: rtl/matmul_apb_slave.sv
// APB3 responder for the matmul register file: CONTROL, operand lines, FLAGS and result scratchpad.
// Fixed one-wait-state handshake; owns the engine start pulse and busy flag.
module matmul_apb_slave #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
    parameter int SP_DEPTH   = MAX_DIM * MAX_DIM
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          psel_i,
    input  logic                          penable_i,
    input  logic                          pwrite_i,
    input  logic [MAX_DIM-1:0]            pstrb_i,
    input  logic [ADDR_WIDTH-1:0]         paddr_i,
    input  logic [BUS_WIDTH-1:0]          pwdata_i,
    output logic [BUS_WIDTH-1:0]          prdata_o,
    output logic                          pready_o,
    output logic                          pslverr_o,
    output logic                          busy_o,
    output logic                          start_o,
    output logic [15:0]                   ctrl_o,
    output logic [MAX_DIM*BUS_WIDTH-1:0]  operand_a_o,
    output logic [MAX_DIM*BUS_WIDTH-1:0]  operand_b_o,
    input  logic                          done_i,
    input  logic [BUS_WIDTH-1:0]          flags_i,
    input  logic                          sp_we_i,
    input  logic [$clog2(SP_DEPTH)-1:0]   sp_addr_i,
    input  logic [BUS_WIDTH-1:0]          sp_wdata_i
);

    localparam int LINE_W = $clog2(MAX_DIM);
    localparam int SP_AW  = $clog2(SP_DEPTH);

    localparam logic [4:0] REG_CONTROL   = 5'b00000;
    localparam logic [4:0] REG_OPERAND_A = 5'b00100;
    localparam logic [4:0] REG_OPERAND_B = 5'b01000;
    localparam logic [4:0] REG_FLAGS     = 5'b01100;
    localparam logic [4:0] REG_SP        = 5'b10000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_SETUP    = 2'b01,
        ST_ACCESS   = 2'b10,
        ST_COMPLETE = 2'b11
    } state_t;

    // Byte-lane merge shared by operand and CONTROL writes.
    function automatic logic [BUS_WIDTH-1:0] merge_lanes(
        input logic [BUS_WIDTH-1:0] old_v,
        input logic [BUS_WIDTH-1:0] new_v,
        input logic [MAX_DIM-1:0]   strb
    );
        logic [BUS_WIDTH-1:0] res;
        res = old_v;
        for (int e = 0; e < MAX_DIM; e++) begin
            if (strb[e]) begin
                res[e*DATA_WIDTH +: DATA_WIDTH] = new_v[e*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                res[e*DATA_WIDTH +: DATA_WIDTH] = old_v[e*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        return res;
    endfunction

    state_t                  r_state;
    state_t                  w_state_next;
    logic [15:0]             r_ctrl;
    logic [BUS_WIDTH-1:0]    r_opa [MAX_DIM];
    logic [BUS_WIDTH-1:0]    r_opb [MAX_DIM];
    logic [BUS_WIDTH-1:0]    r_flags;
    logic [BUS_WIDTH-1:0]    r_sp [SP_DEPTH];
    logic [BUS_WIDTH-1:0]    r_prdata;
    logic                    r_pready;
    logic                    r_pslverr;
    logic                    r_busy;
    logic                    r_start;
    logic                    r_wr_pend;
    logic [4:0]              r_wr_region;
    logic [LINE_W-1:0]       r_wr_line;
    logic [BUS_WIDTH-1:0]    r_wr_data;
    logic [MAX_DIM-1:0]      r_wr_strb;

    logic [4:0]              w_region;
    logic [LINE_W-1:0]       w_line;
    logic [SP_AW-1:0]        w_sp_idx;
    logic                    w_region_valid;
    logic                    w_is_data_reg;
    logic                    w_is_read_only;
    logic                    w_err;
    logic [BUS_WIDTH-1:0]    w_rdata;
    logic                    w_enter_complete;
    logic                    w_commit;
    logic                    w_start;
    logic [BUS_WIDTH-1:0]    w_ctrl_merged;
    logic                    w_unused_addr;

    assign w_region       = paddr_i[4:0];
    assign w_line         = paddr_i[5 +: LINE_W];
    assign w_sp_idx       = paddr_i[5 +: SP_AW];
    assign w_unused_addr  = ^paddr_i[ADDR_WIDTH-1:5+SP_AW];
    assign w_is_data_reg  = (w_region == REG_CONTROL) || (w_region == REG_OPERAND_A) ||
                            (w_region == REG_OPERAND_B);
    assign w_is_read_only = (w_region == REG_FLAGS) || (w_region == REG_SP);
    assign w_region_valid = w_is_data_reg || w_is_read_only;
    // Busy is judged on the registered flag so a write racing its own start is still refused.
    assign w_err          = !w_region_valid || (pwrite_i && w_is_read_only) ||
                            (pwrite_i && w_is_data_reg && r_busy);
    assign w_ctrl_merged  = merge_lanes({{(BUS_WIDTH-16){1'b0}}, r_ctrl}, r_wr_data, r_wr_strb);

    // Read data multiplexer for the addressed region.
    always_comb begin
        w_rdata = {BUS_WIDTH{1'b0}};
        case (w_region)
            REG_CONTROL:   w_rdata = {{(BUS_WIDTH-16){1'b0}}, r_ctrl};
            REG_OPERAND_A: w_rdata = r_opa[w_line];
            REG_OPERAND_B: w_rdata = r_opb[w_line];
            REG_FLAGS:     w_rdata = r_flags;
            REG_SP:        w_rdata = r_sp[w_sp_idx];
            default:       w_rdata = {BUS_WIDTH{1'b0}};
        endcase
    end

    // APB handshake state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // APB handshake next-state logic; ACCESS without a preceding SETUP is ignored.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (psel_i && !penable_i) w_state_next = ST_SETUP;
                else                      w_state_next = ST_IDLE;
            end
            ST_SETUP: begin
                if (!psel_i)        w_state_next = ST_IDLE;
                else if (penable_i) w_state_next = ST_ACCESS;
                else                w_state_next = ST_SETUP;
            end
            ST_ACCESS: begin
                if (psel_i) w_state_next = ST_COMPLETE;
                else        w_state_next = ST_IDLE;
            end
            ST_COMPLETE: begin
                if (psel_i && !penable_i) w_state_next = ST_SETUP;
                else                      w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // APB handshake decoded actions.
    always_comb begin
        w_enter_complete = 1'b0;
        w_commit         = 1'b0;
        w_start          = 1'b0;
        if (r_state == ST_ACCESS) begin
            w_enter_complete = psel_i;
        end else begin
            w_enter_complete = 1'b0;
        end
        if (r_state == ST_COMPLETE) begin
            w_commit = r_wr_pend;
        end else begin
            w_commit = 1'b0;
        end
        w_start = w_commit && (r_wr_region == REG_CONTROL) && r_wr_data[0] &&
                  r_wr_strb[0] && !r_busy;
    end

    // Completion response and the write captured for commit at the end of COMPLETE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pready    <= 1'b0;
            r_pslverr   <= 1'b0;
            r_prdata    <= {BUS_WIDTH{1'b0}};
            r_wr_pend   <= 1'b0;
            r_wr_region <= 5'b00000;
            r_wr_line   <= {LINE_W{1'b0}};
            r_wr_data   <= {BUS_WIDTH{1'b0}};
            r_wr_strb   <= {MAX_DIM{1'b0}};
        end else begin
            r_pready  <= w_enter_complete;
            r_pslverr <= w_enter_complete && w_err;
            r_prdata  <= (w_enter_complete && !pwrite_i) ? w_rdata : {BUS_WIDTH{1'b0}};
            r_wr_pend <= w_enter_complete && pwrite_i && !w_err;
            if (w_enter_complete) begin
                r_wr_region <= w_region;
                r_wr_line   <= w_line;
                r_wr_data   <= pwdata_i;
                r_wr_strb   <= pstrb_i;
            end
        end
    end

    // CONTROL and operand registers; the start bit is never stored.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ctrl <= 16'h0000;
            for (int i = 0; i < MAX_DIM; i++) begin
                r_opa[i] <= {BUS_WIDTH{1'b0}};
                r_opb[i] <= {BUS_WIDTH{1'b0}};
            end
        end else if (w_commit) begin
            case (r_wr_region)
                REG_CONTROL:   r_ctrl <= w_ctrl_merged[15:0] & 16'hFFFE;
                REG_OPERAND_A: r_opa[r_wr_line] <= merge_lanes(r_opa[r_wr_line], r_wr_data, r_wr_strb);
                REG_OPERAND_B: r_opb[r_wr_line] <= merge_lanes(r_opb[r_wr_line], r_wr_data, r_wr_strb);
                default: ;
            endcase
        end
    end

    // Engine run flag; a start in the same cycle as done keeps the engine busy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_busy  <= 1'b0;
            r_start <= 1'b0;
        end else begin
            r_start <= w_start;
            if (w_start)     r_busy <= 1'b1;
            else if (done_i) r_busy <= 1'b0;
        end
    end

    // Flags captured whenever the engine reports done.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_flags <= {BUS_WIDTH{1'b0}};
        end else if (done_i) begin
            r_flags <= flags_i;
        end
    end

    // Result scratchpad, written only by the engine.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SP_DEPTH; i++) begin
                r_sp[i] <= {BUS_WIDTH{1'b0}};
            end
        end else if (sp_we_i) begin
            r_sp[sp_addr_i] <= sp_wdata_i;
        end
    end

    for (genvar g = 0; g < MAX_DIM; g++) begin : g_flat
        assign operand_a_o[g*BUS_WIDTH +: BUS_WIDTH] = r_opa[g];
        assign operand_b_o[g*BUS_WIDTH +: BUS_WIDTH] = r_opb[g];
    end

    assign prdata_o  = r_prdata;
    assign pready_o  = r_pready;
    assign pslverr_o = r_pslverr;
    assign busy_o    = r_busy;
    assign start_o   = r_start;
    assign ctrl_o    = r_ctrl;

endmodule

// File: tb/tb_matmul_apb_slave.sv
// Self-checking bench for matmul_apb_slave: directed scenarios plus random APB/engine
// traffic compared against a register-level reference model.
module tb_matmul_apb_slave;

    localparam logic [4:0] RG_CTRL  = 5'b00000;
    localparam logic [4:0] RG_OPA   = 5'b00100;
    localparam logic [4:0] RG_OPB   = 5'b01000;
    localparam logic [4:0] RG_FLAGS = 5'b01100;
    localparam logic [4:0] RG_SP    = 5'b10000;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [3:0]   pstrb = 4'h0;
    logic [15:0]  paddr = 16'h0;
    logic [31:0]  pwdata = 32'h0;
    logic [31:0]  prdata;
    logic         pready, pslverr, busy, start;
    logic [15:0]  ctrl;
    logic [127:0] opa, opb;
    logic         done_i = 1'b0;
    logic [31:0]  flags_i = 32'h0;
    logic         sp_we = 1'b0;
    logic [3:0]   sp_addr = 4'h0;
    logic [31:0]  sp_wdata = 32'h0;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [15:0] m_ctrl;
    logic [31:0] m_opa [4];
    logic [31:0] m_opb [4];
    logic [31:0] m_flags;
    logic [31:0] m_sp [16];
    bit          m_busy;

    matmul_apb_slave dut (
        .clk_i(clk), .rst_ni(rst_ni), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .pstrb_i(pstrb), .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata),
        .pready_o(pready), .pslverr_o(pslverr), .busy_o(busy), .start_o(start), .ctrl_o(ctrl),
        .operand_a_o(opa), .operand_b_o(opb), .done_i(done_i), .flags_i(flags_i),
        .sp_we_i(sp_we), .sp_addr_i(sp_addr), .sp_wdata_i(sp_wdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ctrl = 16'h0; m_flags = 32'h0; m_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin m_opa[i] = 32'h0; m_opb[i] = 32'h0; end
        for (int i = 0; i < 16; i++) m_sp[i] = 32'h0;
    endtask

    function automatic bit model_err(input bit wr, input logic [4:0] rg);
        bit valid = (rg == RG_CTRL) || (rg == RG_OPA) || (rg == RG_OPB) ||
                    (rg == RG_FLAGS) || (rg == RG_SP);
        if (!valid) return 1'b1;
        if (wr && (rg == RG_FLAGS || rg == RG_SP)) return 1'b1;
        if (wr && m_busy) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] rg, input int idx);
        case (rg)
            RG_CTRL:  return {16'h0, m_ctrl};
            RG_OPA:   return m_opa[idx % 4];
            RG_OPB:   return m_opb[idx % 4];
            RG_FLAGS: return m_flags;
            RG_SP:    return m_sp[idx];
            default:  return 32'h0;
        endcase
    endfunction

    task automatic check_outputs(input bit exp_start);
        logic [127:0] fa, fb;
        for (int i = 0; i < 4; i++) begin fa[i*32 +: 32] = m_opa[i]; fb[i*32 +: 32] = m_opb[i]; end
        check_eq("start_o", start, exp_start);
        check_eq("busy_o", busy, m_busy);
        check_eq("ctrl_o", ctrl, m_ctrl);
        check_eq("operand_a_o", opa, fa);
        check_eq("operand_b_o", opb, fb);
        check_eq("pready_idle", pready, 1'b0);
    endtask

    // Raw APB transfer; optional done pulse on the commit edge and engine SP write on the read edge.
    task automatic apb(input bit wr, input logic [15:0] addr, input logic [31:0] wd, input logic [3:0] st,
                       input bit dn, input logic [31:0] df, input bit sw, input logic [31:0] swd,
                       output logic [31:0] rd, output bit er, output int lat);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
        @(posedge clk); #1;
        penable = 1'b1;
        lat = 0; rd = 32'h0; er = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (sw && lat == 2) begin sp_we = 1'b1; sp_addr = addr[8:5]; sp_wdata = swd; end
            if (lat == 3) sp_we = 1'b0;
            if (pready) begin rd = prdata; er = pslverr; break; end
        end
        sp_we = 1'b0;
        if (dn) begin done_i = 1'b1; flags_i = df; end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; done_i = 1'b0;
    endtask

    task automatic xfer(input bit wr, input logic [4:0] rg, input int idx, input logic [31:0] wd,
                        input logic [3:0] st, input bit dn, input logic [31:0] df,
                        input bit sw, input logic [31:0] swd, output logic [31:0] rd);
        bit exp_err, er, exp_start;
        logic [31:0] exp_rd;
        logic [3:0] idx4;
        int lat;
        idx4 = idx[3:0];
        exp_err = model_err(wr, rg);
        exp_rd  = (!wr && !exp_err) ? model_read(rg, idx) : 32'h0;
        apb(wr, {7'b0, idx4, rg}, wd, st, dn, df, sw, swd, rd, er, lat);
        check_eq("pready_latency", lat, 3);
        check_eq("pslverr", er, exp_err);
        check_eq("prdata", rd, exp_rd);
        exp_start = 1'b0;
        if (wr && !exp_err) begin
            if (rg == RG_CTRL) begin
                for (int b = 0; b < 2; b++) if (st[b]) m_ctrl[b*8 +: 8] = wd[b*8 +: 8];
                exp_start = wd[0] && st[0];
                m_ctrl[0] = 1'b0;
            end else begin
                for (int e = 0; e < 4; e++) begin
                    if (st[e] && rg == RG_OPA) m_opa[idx % 4][e*8 +: 8] = wd[e*8 +: 8];
                    if (st[e] && rg == RG_OPB) m_opb[idx % 4][e*8 +: 8] = wd[e*8 +: 8];
                end
            end
        end
        if (dn) begin m_flags = df; m_busy = 1'b0; end
        if (exp_start) m_busy = 1'b1;
        if (sw) m_sp[idx] = swd;
        @(negedge clk);
        check_outputs(exp_start);
    endtask

    task automatic engine_done(input logic [31:0] f);
        @(posedge clk); #1; done_i = 1'b1; flags_i = f;
        @(posedge clk); #1; done_i = 1'b0;
        m_flags = f; m_busy = 1'b0;
        @(negedge clk);
        check_eq("busy_after_done", busy, 1'b0);
    endtask

    task automatic engine_sp_write(input logic [3:0] a, input logic [31:0] d);
        @(posedge clk); #1; sp_we = 1'b1; sp_addr = a; sp_wdata = d;
        @(posedge clk); #1; sp_we = 1'b0;
        m_sp[a] = d;
    endtask

    initial begin
        logic [31:0] rd;
        int seen;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_prdata", prdata, 32'h0);
        check_eq("reset_pslverr", pslverr, 1'b0);
        check_outputs(1'b0);
        @(posedge clk); #1 rst_ni = 1'b1;

        // Full-line and strobed operand writes
        xfer(1'b1, RG_OPA, 2, 32'h04030201, 4'b1111, 1'b0, 32'h0, 1'b0, 32'h0, rd);
        check_eq("opa_line2", opa[95:64], 32'h04030201);
        xfer(1'b0, RG_OPA, 2, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, rd);
        xfer(1'b1, RG_OPB, 0, 32'hAABBCCDD, 4'b0101, 1'b0, 32'h0, 1'b0, 32'h0, rd);
        xfer(1'b0, RG_OPB, 0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, rd);
        check_eq("opb_strobed_read", rd, 32'h00BB00DD);

        // Start, busy protection, done and flags
        xfer(1'b1, RG_CTRL, 0, 32'h00003F01, 4'b0011, 1'b0, 32'h0, 1'b0, 32'h0, rd);
        @(negedge clk);
        check_eq("start_one_cycle", start, 1'b0);
        check_eq("busy_held", busy, 1'b1);
        xfer(1'b1, RG_OPA, 2, 32'hFFFFFFFF, 4'b1111, 1'b0, 32'h0, 1'b0, 32'h0, rd);
        engine_done(32'h5);
        xfer(1'b0, RG_FLAGS, 0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, rd);
        check_eq("flags_read", rd, 32'h5);
        xfer(1'b0, RG_CTRL, 0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, rd);
        check_eq("ctrl_read", rd, 32'h3F00);

        // Scratchpad and read-only regions
        engine_sp_write(4'd9, 32'hDEADBEEF);
        xfer(1'b0, RG_SP, 9, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, rd);
        check_eq("sp9_read", rd, 32'hDEADBEEF);
        xfer(1'b1, RG_SP, 9, 32'h12345678, 4'hF, 1'b0, 32'h0, 1'b0, 32'h0, rd);
        xfer(1'b1, RG_FLAGS, 0, 32'h12345678, 4'hF, 1'b0, 32'h0, 1'b0, 32'h0, rd);
        xfer(1'b0, RG_SP, 9, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, rd);
        xfer(1'b0, RG_FLAGS, 0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, rd);
        // Engine write on the same edge as the read returns old data
        xfer(1'b0, RG_SP, 9, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 32'hCAFEF00D, rd);
        check_eq("sp_same_cycle_old", rd, 32'hDEADBEEF);
        xfer(1'b0, RG_SP, 9, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, rd);

        // Invalid region
        xfer(1'b0, 5'b00010, 0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, rd);

        // Aborted transfer: psel drops during ACCESS
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = {7'b0, 4'd1, RG_OPA};
        pwdata = 32'h99999999; pstrb = 4'hF;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        seen = 0;
        repeat (3) begin @(negedge clk); if (pready) seen++; end
        check_eq("abort_no_pready", seen, 0);
        check_outputs(1'b0);

        // done_i on the same edge as a start commit: start wins
        xfer(1'b1, RG_CTRL, 0, 32'h00000001, 4'b0001, 1'b1, 32'h0000ABCD, 1'b0, 32'h0, rd);
        engine_done(32'h0);

        // Random traffic
        for (int it = 0; it < 150; it++) begin
            int sel, idx;
            logic [4:0] rg;
            logic [31:0] d;
            sel = $urandom_range(0, 9);
            idx = $urandom_range(0, 15);
            d = $urandom;
            if (sel == 0) begin
                engine_done(d);
            end else if (sel == 1) begin
                engine_sp_write(idx[3:0], d);
            end else begin
                case ($urandom_range(0, 6))
                    0: rg = RG_CTRL;
                    1: rg = RG_OPA;
                    2: rg = RG_OPB;
                    3: rg = RG_FLAGS;
                    4: rg = RG_SP;
                    5: rg = RG_OPA;
                    default: rg = 5'($urandom_range(0, 31));
                endcase
                xfer(1'($urandom_range(0, 1)), rg, idx, d, 4'($urandom_range(0, 15)),
                     1'b0, 32'h0, 1'b0, 32'h0, rd);
            end
        end

        // Reset while busy and mid-write
        engine_done(32'h7);
        xfer(1'b1, RG_CTRL, 0, 32'h00000001, 4'b0001, 1'b0, 32'h0, 1'b0, 32'h0, rd);
        xfer(1'b1, RG_OPA, 3, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, rd);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = {7'b0, 4'd1, RG_OPA};
        pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #2 rst_ni = 1'b0;
        #1;
        model_reset();
        check_eq("rst_prdata", prdata, 32'h0);
        check_eq("rst_pslverr", pslverr, 1'b0);
        check_outputs(1'b0);
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        seen = 0;
        repeat (4) begin @(negedge clk); if (pready) seen++; end
        check_eq("no_access_without_setup", seen, 0);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, RG_OPA, i, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, rd);
            xfer(1'b0, RG_OPB, i, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, rd);
        end
        xfer(1'b0, RG_FLAGS, 0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, rd);
        xfer(1'b0, RG_SP, 9, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, rd);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matmul_apb_slave.md
# matmul_apb_slave

APB3 responder that terminates the matmul register interface driven by the testbench stimulus master. It decodes `paddr_i` into the CONTROL, OPERAND_A, OPERAND_B, FLAGS and SP regions and holds the operand and control registers consumed by the matmul calculation engine. It also generates `pready_o`, `prdata_o` and `pslverr_o`, and owns `busy_o` from start until the engine reports done. It sits between `matmul_intf` and the engine core inside the matmul top.

## Interface
- DATA_WIDTH, 8: element width in bits.
- BUS_WIDTH, 32: APB data width; one operand line.
- ADDR_WIDTH, 16: APB address width.
- MAX_DIM, BUS_WIDTH/DATA_WIDTH (4): matrix dimension limit; `pstrb` width; operand lines per matrix.
- SP_DEPTH, MAX_DIM*MAX_DIM (16): scratchpad (result) entries.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- psel_i, penable_i, pwrite_i  in  1 each  APB control.
- pstrb_i  in  MAX_DIM  element-lane write strobes.
- paddr_i  in  ADDR_WIDTH  address; [4:0] region, [5+:log2(MAX_DIM)] line, [5+:log2(SP_DEPTH)] SP index.
- pwdata_i  in  BUS_WIDTH  write data.
- prdata_o  out  BUS_WIDTH  read data.
- pready_o, pslverr_o  out  1 each  transfer completion and error.
- busy_o  out  1  engine running.
- start_o  out  1  one-cycle start pulse to the engine.
- ctrl_o  out  16  CONTROL register with bit 0 forced to 0.
- operand_a_o, operand_b_o  out  MAX_DIM*BUS_WIDTH  flattened operand lines; line i sits at [i*BUS_WIDTH+:BUS_WIDTH].
- done_i  in  1  engine finished (one-cycle pulse).
- flags_i  in  BUS_WIDTH  engine flags, captured on done_i.
- sp_we_i  in  1; sp_addr_i  in  log2(SP_DEPTH); sp_wdata_i  in  BUS_WIDTH  engine result write port.

## Operation
- Region codes on paddr_i[4:0]: CONTROL=5'b00000, OPERAND_A=5'b00100, OPERAND_B=5'b01000, FLAGS=5'b01100, SP=5'b10000. Any other code is invalid.
- CONTROL fields: [0] start, [1] mode, [3:2] write_target, [5:4] read_target, [9:8] n, [11:10] k, [13:12] m. Bits [7:6] and [15:14] are stored as written.
- Write strobes:
  - OPERAND lines: `pstrb_i[e]` enables element e, i.e. bits [e*DATA_WIDTH+:DATA_WIDTH].
  - CONTROL: `pstrb_i[0]` enables bits [7:0]; `pstrb_i[1]` enables bits [15:8].
  - SP writes are not permitted (see error rules).
- Start: a committed CONTROL write with `pwdata_i[0]=1` and lane 0 strobed, while `busy_o=0`, has these effects:
  - `start_o`=1 for exactly one cycle, in the cycle after commit.
  - `busy_o` goes to 1 in that same cycle.
  - The stored start bit always reads back as 0.
- done_i=1 has these effects:
  - `busy_o` goes to 0 on the next edge.
  - `flags_i` is latched into the FLAGS register.
  - done_i while idle only latches flags.
- Error (`pslverr_o`=1 together with `pready_o`, no state change) on:
  - an invalid region;
  - a write to FLAGS or SP;
  - a write to CONTROL or OPERAND_A/B while `busy_o`=1, judged on the registered `busy_o` value.
- Reads never change state:
  - CONTROL returns zero-extended [15:0].
  - OPERAND_A/B return the addressed line.
  - FLAGS returns the latched flags.
  - SP returns the entry at paddr_i[5+:log2(SP_DEPTH)].
  - Reads of an invalid region return 0 and flag an error.
- Engine SP writes (sp_we_i) are always accepted, including during APB reads. A same-cycle engine write and APB read of the same entry returns the old data.

## Timing
- APB state machine:
  - IDLE: psel_i=0.
  - SETUP: psel_i=1, penable_i=0.
  - ACCESS: penable_i=1. Exactly one wait state, so `pready_o` rises in the cycle after ACCESS is entered.
  - COMPLETE: `pready_o`=1 for exactly one cycle, then return to IDLE. If psel_i=1 and penable_i=0 at that point, go to SETUP instead.
- Completion signals:
  - `prdata_o` and `pslverr_o` are registered and valid only while `pready_o`=1; otherwise both are 0.
  - A write commits at the rising edge where `pready_o`=1.
- Read latency is 2 cycles from the SETUP edge to data.
- psel_i dropping during ACCESS aborts the transfer: no commit, back to IDLE.
- Reset values:
  - All outputs 0, including prdata_o, pready_o, pslverr_o, busy_o, start_o and ctrl_o.
  - Operand lines, FLAGS and SP are cleared to 0.
- Reset asserted mid-transfer or mid-busy clears everything immediately; a following ACCESS with no fresh SETUP is ignored.
- done_i arriving in the same cycle as a start commit: busy_o ends at 1, because start wins.

## Test plan
- Reset, then write OPERAND_A line 2 = 32'h04_03_02_01 with pstrb 4'b1111. Expect pready on the 2nd cycle after SETUP, pslverr=0, and operand_a_o[95:64]=32'h04030201. A readback returns the same value.
- Write OPERAND_B line 0 = 32'hAABBCCDD with pstrb 4'b0101 over an old value of 0. Expect the line to read 32'h00BB00DD.
- CONTROL write 16'h3F01 → start_o is a single pulse and busy_o=1. A subsequent OPERAND_A write gets pslverr=1 and the line is unchanged. done_i with flags_i=32'h5 → busy_o=0 next cycle and a FLAGS read returns 5. A CONTROL read returns 16'h3F00.
- Engine writes SP[9]=32'hDEAD_BEEF. An APB read of SP index 9 returns it. An APB write to SP or FLAGS gets pslverr=1, and reads still return the old values.
- Read region 5'b00010 → pslverr=1, prdata=0. Drop psel during ACCESS → no pready and no commit.
- Assert rst_ni=0 while busy and mid-write → every output is 0 immediately and the operand lines read 0 after release.
